cond_pipe_unit: RTL and testbench
=================================

Name: cond_pipe_unit

Overview:
- Execute-to-Memory condition stage that sits directly downstream of the ALU.
- Holds the architectural NZCV flag register and updates it from the ALU's 4-bit ALUFlags under FlagW control.
- Evaluates the instruction's 4-bit condition field against the stored flags and gates the write/branch controls.
- Registers the gated controls into the Memory stage, with stall and flush support.

Parameters:
- FLAG_RESET, 4'b0000, reset value of the NZCV flag register.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  stage enable; 0 = stall (hold all state)
- flush  input  1  squash the Execute-stage instruction
- ValidE  input  1  Execute stage holds a real instruction
- Cond  input  4  ARM-style condition field of the Execute instruction
- ALUFlags  input  4  {N,Z,C,V} from ALU, bit3 = N ... bit0 = V
- FlagW  input  2  bit1: write N,Z; bit0: write C,V
- PCS  input  1  instruction writes PC (branch / PC destination)
- RegW  input  1  instruction writes register file
- MemW  input  1  instruction writes memory
- NoWrite  input  1  compare-type op; suppresses RegW only
- CondExE  output  1  combinational condition-passed for the Execute instruction
- Flags  output  4  registered NZCV, same bit order as ALUFlags
- ValidM  output  1  Memory-stage valid
- PCSrcM  output  1  registered gated PCS
- RegWriteM  output  1  registered gated RegW
- MemWriteM  output  1  registered gated MemW

Behaviour:
- Reset (synchronous, highest priority):
  - Flags <= FLAG_RESET.
  - ValidM, PCSrcM, RegWriteM and MemWriteM <= 0.
- Condition evaluation is combinational on Cond and the registered Flags, i.e. the flags as they stood before this instruction. Table:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - A GE: N == V
  - B LT: N != V
  - C GT: !Z & (N == V)
  - D LE: Z | (N != V)
  - E AL: 1
  - F: 1 (treated as always)
- Define live = ValidE & CondExE & !flush.
- Flag update at the edge, when en = 1 and live:
  - If FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
  - Unselected bits hold. A failed condition never updates flags.
- Memory register at the edge, when en = 1:
  - ValidM <= ValidE & !flush.
  - PCSrcM <= live & PCS.
  - RegWriteM <= live & RegW & !NoWrite.
  - MemWriteM <= live & MemW.
- Latency: a flag update is visible on Flags and CondExE in the cycle after the updating edge. There is no same-cycle flag forwarding. Back-to-back dependent instructions therefore see the updated flags.
- Stall (en = 0, flush = 0): Flags and all M registers hold. CondExE keeps tracking its inputs.
- Flush:
  - Overrides stall: with flush = 1 the M registers load zeros even when en = 0.
  - Flags are never written during flush.
- Priority: reset > flush > stall > normal.
- ValidE = 0 behaves as a bubble: no flag write, M controls zero. CondExE still reports the evaluation.
- Reset asserted mid-stall or mid-flush: reset result only. Recovery on the first cycle after deassertion.
- X-free: all outputs are driven from reset onward. Undefined Cond values do not exist (all 16 are decoded).

Test Plan:
- Reset, then ADDS-style update: ValidE=1, Cond=E, FlagW=11, ALUFlags=0110.
  - Next cycle: Flags=0110.
  - Then Cond=0 (EQ) -> CondExE=1; Cond=1 (NE) -> CondExE=0.
- Partial update: Flags=1111, FlagW=10, ALUFlags=0000 -> Flags=0011. Then FlagW=01, ALUFlags=0000 -> Flags=0000.
- Failed condition: Flags=0100 (Z=1), Cond=1, RegW=1, MemW=1, PCS=1, FlagW=11, ALUFlags=1001.
  - CondExE=0.
  - Next cycle: RegWriteM=MemWriteM=PCSrcM=0, ValidM=1, Flags still 0100.
- Signed compares: sweep all 16 Cond values for each of Flags=1000, 1001, 0001, 0100; compare CondExE against the table.
  - Example: Flags=1001 gives GE=1, LT=0, GT=1.
  - Compare op: NoWrite=1, RegW=1, FlagW=11 -> RegWriteM=0 and flags updated.
- Stall/flush:
  - en=0 for 3 cycles while inputs change -> Flags and M outputs frozen.
  - flush=1 with en=0 -> M outputs 0 next edge, Flags unchanged.
  - flush=1 with FlagW=11 -> no flag write.
- Reset mid-operation: Flags=1010 and RegWriteM=1, then reset=1 for one cycle together with flush=0, en=1, live update inputs.
  - Flags=FLAG_RESET and all M outputs 0.
  - The following live instruction updates normally.

Source files
------------

// File: rtl/cond_pipe_unit.sv
// Execute-to-Memory condition stage: holds NZCV, evaluates the condition
// field of the Execute instruction, and registers the gated write/branch
// controls into the Memory stage with stall and flush support.
module cond_pipe_unit #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       flush,
    input  logic       ValidE,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       CondExE,
    output logic [3:0] Flags,
    output logic       ValidM,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemWriteM
);

    logic neg;
    logic zero;
    logic carry;
    logic ovf;
    logic live;

    assign neg   = Flags[3];
    assign zero  = Flags[2];
    assign carry = Flags[1];
    assign ovf   = Flags[0];

    // Decode the condition against the flags as they stood before this instruction
    always_comb begin
        CondExE = 1'b1;
        case (Cond)
            4'h0:    CondExE = zero;
            4'h1:    CondExE = ~zero;
            4'h2:    CondExE = carry;
            4'h3:    CondExE = ~carry;
            4'h4:    CondExE = neg;
            4'h5:    CondExE = ~neg;
            4'h6:    CondExE = ovf;
            4'h7:    CondExE = ~ovf;
            4'h8:    CondExE = carry & ~zero;
            4'h9:    CondExE = ~carry | zero;
            4'hA:    CondExE = (neg == ovf);
            4'hB:    CondExE = (neg != ovf);
            4'hC:    CondExE = ~zero & (neg == ovf);
            4'hD:    CondExE = zero | (neg != ovf);
            default: CondExE = 1'b1;
        endcase
    end

    // A real, unsquashed instruction whose condition passed
    assign live = ValidE & CondExE & ~flush;

    // Flag register: only live instructions write the selected flag pairs
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= FLAG_RESET;
        end else if (en && live) begin
            if (FlagW[1]) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Memory-stage controls: flush loads zeros even while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            ValidM    <= 1'b0;
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else if (flush) begin
            ValidM    <= 1'b0;
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else if (en) begin
            ValidM    <= ValidE;
            PCSrcM    <= live & PCS;
            RegWriteM <= live & RegW & ~NoWrite;
            MemWriteM <= live & MemW;
        end
    end

endmodule

// File: tb/tb_cond_pipe_unit.sv
// Self-checking bench for cond_pipe_unit: directed steps from the test plan
// followed by randomized traffic, all checked against a behavioural model.
module tb_cond_pipe_unit;

    localparam logic [3:0] FLAG_RESET = 4'b0000;

    logic       clk;
    logic       reset;
    logic       en;
    logic       flush;
    logic       ValidE;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       CondExE;
    logic [3:0] Flags;
    logic       ValidM;
    logic       PCSrcM;
    logic       RegWriteM;
    logic       MemWriteM;

    int checks   = 0;
    int failures = 0;

    logic [3:0] model_flags;
    logic       model_validm;
    logic       model_pcsrcm;
    logic       model_regwm;
    logic       model_memwm;
    logic       model_known = 1'b0;

    cond_pipe_unit #(.FLAG_RESET(FLAG_RESET)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .flush(flush),
        .ValidE(ValidE),
        .Cond(Cond),
        .ALUFlags(ALUFlags),
        .FlagW(FlagW),
        .PCS(PCS),
        .RegW(RegW),
        .MemW(MemW),
        .NoWrite(NoWrite),
        .CondExE(CondExE),
        .Flags(Flags),
        .ValidM(ValidM),
        .PCSrcM(PCSrcM),
        .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Condition rules: even codes test a base predicate, odd codes its inverse, 14/15 always
    function automatic logic ref_cond(input logic [3:0] cnd, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic base;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cnd[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cnd == 4'hF) return 1'b1;
        return cnd[0] ? !base : base;
    endfunction

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".Flags"}, Flags, model_flags);
        check({tag, ".ValidM"}, {3'b0, ValidM}, {3'b0, model_validm});
        check({tag, ".PCSrcM"}, {3'b0, PCSrcM}, {3'b0, model_pcsrcm});
        check({tag, ".RegWriteM"}, {3'b0, RegWriteM}, {3'b0, model_regwm});
        check({tag, ".MemWriteM"}, {3'b0, MemWriteM}, {3'b0, model_memwm});
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic e, input logic f,
                                 input logic v, input logic [3:0] cnd, input logic [3:0] alu,
                                 input logic [1:0] fw, input logic p, input logic rw,
                                 input logic mw, input logic nw);
        logic passed;
        logic live;
        reset    = r;
        en       = e;
        flush    = f;
        ValidE   = v;
        Cond     = cnd;
        ALUFlags = alu;
        FlagW    = fw;
        PCS      = p;
        RegW     = rw;
        MemW     = mw;
        NoWrite  = nw;
        #1;
        passed = ref_cond(cnd, model_flags);
        if (model_known) check({tag, ".CondExE"}, {3'b0, CondExE}, {3'b0, passed});
        live = v && passed && !f;
        if (r) begin
            model_flags  = FLAG_RESET;
            model_validm = 1'b0;
            model_pcsrcm = 1'b0;
            model_regwm  = 1'b0;
            model_memwm  = 1'b0;
            model_known  = 1'b1;
        end else begin
            if (e && live) begin
                if (fw[1]) model_flags[3:2] = alu[3:2];
                if (fw[0]) model_flags[1:0] = alu[1:0];
            end
            if (f) begin
                model_validm = 1'b0;
                model_pcsrcm = 1'b0;
                model_regwm  = 1'b0;
                model_memwm  = 1'b0;
            end else if (e) begin
                model_validm = v;
                model_pcsrcm = live && p;
                model_regwm  = live && rw && !nw;
                model_memwm  = live && mw;
            end
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic setFlags(input logic [3:0] value);
        applyStimulus("setflags", 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, value, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bubble(input string tag, input logic [3:0] cnd);
        applyStimulus(tag, 1'b0, 1'b1, 1'b0, 1'b0, cnd, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Directed test-plan steps followed by randomized traffic
    initial begin
        logic [3:0] patterns [4];
        patterns[0] = 4'b1000;
        patterns[1] = 4'b1001;
        patterns[2] = 4'b0001;
        patterns[3] = 4'b0100;

        applyStimulus("reset", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_flags", Flags, FLAG_RESET);

        applyStimulus("adds", 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        check("adds_flags", Flags, 4'b0110);
        bubble("eq_after_adds", 4'h0);
        check("eq_passes", {3'b0, CondExE}, 4'b0001);
        bubble("ne_after_adds", 4'h1);
        check("ne_fails", {3'b0, CondExE}, 4'b0000);

        setFlags(4'b1111);
        applyStimulus("partial_nz", 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        check("partial_nz_flags", Flags, 4'b0011);
        applyStimulus("partial_cv", 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        check("partial_cv_flags", Flags, 4'b0000);

        setFlags(4'b0100);
        applyStimulus("failed_cond", 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        check("failed_validm", {3'b0, ValidM}, 4'b0001);
        check("failed_regwm", {3'b0, RegWriteM}, 4'b0000);
        check("failed_flags", Flags, 4'b0100);

        for (int p = 0; p < 4; p++) begin
            setFlags(patterns[p]);
            for (int c = 0; c < 16; c++) begin
                bubble("sweep", c[3:0]);
            end
        end

        setFlags(4'b1001);
        bubble("ge_1001", 4'hA);
        check("ge_1001_const", {3'b0, CondExE}, 4'b0001);
        bubble("gt_1001", 4'hC);
        check("gt_1001_const", {3'b0, CondExE}, 4'b0001);

        applyStimulus("compare_op", 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        check("compare_regwm", {3'b0, RegWriteM}, 4'b0000);
        check("compare_flags", Flags, 4'b1010);

        applyStimulus("load_m", 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'b0101, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            applyStimulus("stall", 1'b0, 1'b0, 1'b0, s[0], 4'(s * 5), 4'(s + 9), 2'b11, 1'b0, s[0], 1'b1, 1'b0);
            check("stall_flags", Flags, 4'b0101);
            check("stall_memwm", {3'b0, MemWriteM}, 4'b0001);
        end
        applyStimulus("flush_stall", 1'b0, 1'b0, 1'b1, 1'b1, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_stall_validm", {3'b0, ValidM}, 4'b0000);
        check("flush_stall_flags", Flags, 4'b0101);
        applyStimulus("flush_run", 1'b0, 1'b1, 1'b1, 1'b1, 4'hE, 4'b1010, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_run_flags", Flags, 4'b0101);

        applyStimulus("pre_reset", 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_reset_regwm", {3'b0, RegWriteM}, 4'b0001);
        applyStimulus("mid_reset", 1'b1, 1'b1, 1'b0, 1'b1, 4'hE, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        check("mid_reset_flags", Flags, FLAG_RESET);
        applyStimulus("post_reset", 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_reset_flags", Flags, 4'b0110);
        applyStimulus("reset_in_flush_stall", 1'b1, 1'b0, 1'b1, 1'b1, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                          ($urandom_range(31) == 0),
                          ($urandom_range(3) != 0),
                          ($urandom_range(7) == 0),
                          ($urandom_range(4) != 0),
                          4'($urandom),
                          4'($urandom),
                          2'($urandom),
                          1'($urandom),
                          1'($urandom),
                          1'($urandom),
                          ($urandom_range(3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
